keypad_scan_ctrl: RTL and testbench

//   Scans a ROWS x COLS matrix keypad: drives one row low at a time, samples the

---
 rtl/keypad_scan_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner with debounce, exposed as an Avalon-MM slave with a level interrupt.
// Rows are driven one-cold, columns are sampled active-low, and each debounced press is latched into DATA.
module keypad_scan_ctrl #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic [ROWS-1:0] row_out,
  input  logic [COLS-1:0] col_in,
  input  logic [1:0]      address,
  input  logic            read,
  input  logic            write,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  output logic            irq
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam int ROW_W = $clog2(ROWS);
  localparam int KEYS  = ROWS * COLS;
  localparam int ONE_W = $clog2(KEYS + 1);
  // Key codes carry a "none" flag in bit 4 so NONE never aliases a real key.
  localparam logic [4:0] NONE = 5'h10;

  typedef enum logic [1:0] {S_OFF, S_DRIVE, S_EVAL} scan_state_t;

  scan_state_t      state;
  logic [ROW_W-1:0] row;
  logic [CNT_W-1:0] dwell;
  logic [KEYS-1:0]  frame_lows;
  logic [4:0]       candidate;
  logic [4:0]       stable;
  logic [DEB_W-1:0] deb_cnt;

  logic [COLS-1:0]  col_meta;
  logic [COLS-1:0]  col_sync;

  logic [1:0]       ctrl;
  logic             valid;
  logic             overrun;
  logic [3:0]       code;

  logic             scan_en;
  logic             key_down;
  logic             data_rd;
  logic             press_evt;
  logic [4:0]       frame_code;
  logic [ONE_W-1:0] ones;
  logic [3:0]       one_idx;
  logic [4:0]       cand_n;
  logic [4:0]       stable_n;
  logic [DEB_W-1:0] deb_n;
  logic [31:0]      rd_mux;
  logic             unused_ok;

  assign scan_en   = ctrl[0];
  assign key_down  = (stable != NONE);
  assign data_rd   = read && (address == 2'd0);
  assign unused_ok = ^writedata[31:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  // Exactly one low key in the whole frame yields its code; none or ghosting yields NONE.
  always_comb begin
    ones    = '0;
    one_idx = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (frame_lows[i]) begin
        ones    = ones + ONE_W'(1);
        one_idx = 4'(i);
      end
    end
    frame_code = (ones == ONE_W'(1)) ? {1'b0, one_idx} : NONE;
  end

  always_comb begin
    cand_n   = candidate;
    deb_n    = deb_cnt;
    stable_n = stable;
    if (frame_code == candidate) begin
      if (deb_cnt != DEB_W'(DEBOUNCE)) deb_n = deb_cnt + DEB_W'(1);
    end else begin
      cand_n = frame_code;
      deb_n  = DEB_W'(1);
    end
    if (deb_n == DEB_W'(DEBOUNCE) && cand_n != stable) stable_n = cand_n;
  end

  // Releases update stable silently; only a move onto a real key is an event.
  assign press_evt = (state == S_EVAL) && scan_en &&
                     (stable_n != stable) && (stable_n != NONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_OFF;
      row_out    <= '1;
      row        <= '0;
      dwell      <= '0;
      frame_lows <= '0;
      candidate  <= NONE;
      stable     <= NONE;
      deb_cnt    <= '0;
    end else if (!scan_en) begin
      state      <= S_OFF;
      row_out    <= '1;
      row        <= '0;
      dwell      <= '0;
      frame_lows <= '0;
      candidate  <= NONE;
      stable     <= NONE;
      deb_cnt    <= '0;
    end else begin
      case (state)
        S_OFF: begin
          state   <= S_DRIVE;
          row     <= '0;
          dwell   <= '0;
          row_out <= ~ROWS'(1);
        end
        S_DRIVE: begin
          if (dwell == CNT_W'(SCAN_DIV - 1)) begin
            dwell <= '0;
            frame_lows[int'(row)*COLS +: COLS] <= ~col_sync;
            if (row == ROW_W'(ROWS - 1)) begin
              state   <= S_EVAL;
              row     <= '0;
              row_out <= '1;
            end else begin
              row     <= row + ROW_W'(1);
              row_out <= ~(ROWS'(1) << (row + ROW_W'(1)));
            end
          end else begin
            dwell <= dwell + CNT_W'(1);
          end
        end
        S_EVAL: begin
          candidate <= cand_n;
          deb_cnt   <= deb_n;
          stable    <= stable_n;
          state     <= S_DRIVE;
          row       <= '0;
          row_out   <= ~ROWS'(1);
        end
        default: begin
          state   <= S_OFF;
          row_out <= '1;
        end
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux = {27'd0, valid, code};
      2'd1:    rd_mux = {29'd0, overrun, key_down, valid};
      2'd2:    rd_mux = {30'd0, ctrl};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl     <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
      code     <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (read) readdata <= rd_mux;
      if (write && address == 2'd2) ctrl <= writedata[1:0];
      if (write && address == 2'd1) overrun <= 1'b0;
      if (data_rd) valid <= 1'b0;
      // A DATA read in the same cycle frees the slot, so the new key is taken without overrun.
      if (press_evt) begin
        if (valid && !data_rd) begin
          overrun <= 1'b1;
        end else begin
          code  <= stable_n[3:0];
          valid <= 1'b1;
        end
      end
      irq <= valid & ctrl[1];
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE=2 (one frame = 17 cycles).
// A small keypad model pulls columns low for pressed keys on the currently driven row.
module tb_keypad_scan_ctrl;

  localparam int FRAME = 17;

  logic        clk;
  logic        reset;
  logic [3:0]  row_out;
  logic [3:0]  col_in;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  logic [15:0] keys;
  int          n_tests;
  int          n_fail;

  keypad_scan_ctrl #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2)
  ) dut (
    .clk(clk), .reset(reset), .row_out(row_out), .col_in(col_in),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4 + c] && !row_out[r]) col_in[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    @(negedge clk);
    read    = 1'b0;
    d       = readdata;
  endtask

  // Polls STATUS until valid is set or the cycle budget runs out.
  task automatic wait_valid(input int max_cycles, output logic ok);
    logic [31:0] d;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      bus_read(2'd1, d);
      if (d[0]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        ok;
    int          bad;

    n_tests = 0;
    n_fail  = 0;
    keys = '0; address = '0; read = 0; write = 0; writedata = '0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;

    // Scan disabled: rows idle, bus outputs quiet.
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (row_out !== 4'hF) bad++;
    end
    check("idle_row_out_100", bad, 0);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    bus_read(2'd0, d);
    check("reset_data", d, 32'h0);
    bus_read(2'd1, d);
    check("reset_status", d, 32'h0);

    // Single key row2/col1 = code 9.
    keys[9] = 1'b1;
    bus_write(2'd2, 32'h3);
    bus_read(2'd2, d);
    check("ctrl_readback", d, 32'h3);
    wait_valid(3*FRAME + 6, ok);
    check("t2_valid_within_3_frames", {31'd0, ok}, 32'h1);
    tick(2);
    check("t2_irq_set", {31'd0, irq}, 32'h1);
    bus_read(2'd0, d);
    check("t2_data_first", d, 32'h19);
    tick(2);
    check("t2_irq_clear", {31'd0, irq}, 32'h0);
    bus_read(2'd0, d);
    check("t2_data_second", d, 32'h09);

    // Long hold gives a single event; release and re-press gives another.
    tick(20*FRAME);
    bus_read(2'd1, d);
    check("t3_hold_no_new_event", d, 32'h2);
    keys = '0;
    tick(3*FRAME);
    bus_read(2'd1, d);
    check("t3_released", d, 32'h0);
    keys[9] = 1'b1;
    wait_valid(3*FRAME + 6, ok);
    check("t3_repress_valid", {31'd0, ok}, 32'h1);
    bus_read(2'd0, d);
    check("t3_repress_data", d, 32'h19);
    keys = '0;
    tick(3*FRAME);

    // Key 3 toggling every frame never settles.
    for (int f = 0; f < 6; f++) begin
      keys[3] = (f % 2 == 0);
      tick(FRAME);
    end
    keys[3] = 1'b0;
    bus_read(2'd1, d);
    check("t4_bounce_no_event", d, 32'h0);
    keys[3] = 1'b1;
    wait_valid(3*FRAME + 6, ok);
    check("t4_stable_valid", {31'd0, ok}, 32'h1);
    bus_read(2'd0, d);
    check("t4_stable_data", d, 32'h13);
    keys = '0;
    tick(3*FRAME);

    // Key 5 then key 0xC without reading: second press overruns.
    keys[5] = 1'b1;
    wait_valid(3*FRAME + 6, ok);
    check("t5_first_valid", {31'd0, ok}, 32'h1);
    keys = '0;
    tick(4*FRAME);
    keys[12] = 1'b1;
    tick(4*FRAME);
    // valid, key_down (0xC held) and overrun all set.
    bus_read(2'd1, d);
    check("t5_status_overrun", d, 32'h7);
    bus_write(2'd1, 32'h0);
    bus_read(2'd1, d);
    check("t5_status_cleared", d, 32'h3);
    bus_read(2'd0, d);
    check("t5_data_kept", d, 32'h15);
    keys = '0;
    tick(3*FRAME);

    // Keys 0 and 0xA in different rows: ghosting resolves to no key.
    keys[0]  = 1'b1;
    keys[10] = 1'b1;
    tick(4*FRAME);
    bus_read(2'd1, d);
    check("t6_ghost_no_event", d, 32'h0);

    // Disable while row 2 is being driven.
    ok = 1'b0;
    for (int i = 0; i < 2*FRAME; i++) begin
      if (row_out == 4'hB) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("t6_row2_seen", {31'd0, ok}, 32'h1);
    bus_write(2'd2, 32'h0);
    check("t6_still_driving", {31'd0, row_out == 4'hF}, 32'h0);
    tick(1);
    check("t6_row_out_idle", {28'd0, row_out}, 32'hF);

    // Asynchronous reset in the middle of a frame.
    keys = '0;
    keys[6] = 1'b1;
    bus_write(2'd2, 32'h3);
    wait_valid(3*FRAME + 6, ok);
    check("t7_valid_before_reset", {31'd0, ok}, 32'h1);
    tick(6);
    #3 reset = 1'b1;
    #1;
    check("t7_reset_row_out", {28'd0, row_out}, 32'hF);
    check("t7_reset_irq", {31'd0, irq}, 32'h0);
    check("t7_reset_readdata", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(2'd1, d);
    check("t7_status_after_reset", d, 32'h0);
    bus_read(2'd2, d);
    check("t7_ctrl_after_reset", d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
